// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder: default sizing, the
// trellis-size helper, and the traceback FSM state encoding.
package viterbi_pkg;

  localparam int K_DEF         = 3;
  localparam int FRAME_LEN_DEF = 8;

  // Number of trellis states for constraint length k.
  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  localparam int M_DEF      = K_DEF - 1;
  localparam int NUM_ST_DEF = num_states(K_DEF);

  // Traceback controller states; sliding-window variants reuse this type.
  typedef enum logic {
    TB_IDLE  = 1'b0,
    TB_TRACE = 1'b1
  } tb_state_t;

endpackage

// File: rtl/sv_bank.sv
// One survivor bank: FRAME_LEN columns of per-state decision bits.
// Column-wide write port, single-bit combinational read port.
module sv_bank
  import viterbi_pkg::*;
#(
  parameter int M         = 2,
  parameter int FRAME_LEN = 8,
  parameter int COL_W     = 3
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [COL_W-1:0]           wcol_i,
  input  logic [num_states(M+1)-1:0] wvec_i,
  input  logic [COL_W-1:0]           rcol_i,
  input  logic [M-1:0]               rstate_i,
  output logic                       rbit_o
);

  localparam int NUM_ST = num_states(M + 1);

  logic [NUM_ST-1:0] mem_q [FRAME_LEN];

  // Store one decision vector per accepted step; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wcol_i] <= wvec_i;
    end
  end

  // Same-cycle read so traceback advances one state per output bit.
  assign rbit_o = mem_q[rcol_i][rstate_i];

endmodule

// File: rtl/viterbi_tbu.sv
// Viterbi survivor memory and traceback unit. Two ping-pong banks: one
// frame is written while the other is traced back from its best end
// state, emitting decoded bits last-step-first under valid/ready.
module viterbi_tbu
  import viterbi_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [num_states(K)-1:0] dec_vec,
  input  logic                    dec_last,
  input  logic [K-2:0]            start_state,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic                    out_last
);

  localparam int M      = K - 1;
  localparam int NUM_ST = num_states(K);
  localparam int COL_W  = $clog2(FRAME_LEN);
  localparam int LEN_W  = $clog2(FRAME_LEN + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_LEN - 1);

  // Write side
  logic             wbank_q, wbank_d;
  logic [COL_W-1:0] wcol_q, wcol_d;
  logic [1:0]       full_q, full_d;
  logic [LEN_W-1:0] len_q [2];
  logic [M-1:0]     sst_q [2];

  // Traceback side
  tb_state_t        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [COL_W-1:0] rcol_q, rcol_d;
  logic [M-1:0]     cur_q, cur_d;

  logic       wr_fire;
  logic       wr_close;
  logic       rd_fire;
  logic       rd_done;
  logic [1:0] bank_we;
  logic [1:0] bank_rbit;
  logic       rbit;

  // Ready depends only on registered flags, never on out_ready.
  assign dec_ready = ~full_q[wbank_q];
  assign wr_fire   = dec_valid & dec_ready;
  // A frame also closes when the last column of the bank is written.
  assign wr_close  = wr_fire & (dec_last | (wcol_q == LAST_COL));
  assign bank_we   = wr_fire ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sv_bank #(
      .M        (M),
      .FRAME_LEN(FRAME_LEN),
      .COL_W    (COL_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .wcol_i  (wcol_q),
      .wvec_i  (dec_vec),
      .rcol_i  (rcol_q),
      .rstate_i(cur_q),
      .rbit_o  (bank_rbit[b])
    );
  end

  assign rbit = bank_rbit[rbank_q];

  // Outputs come straight from traceback registers, so they hold while stalled.
  assign out_valid = (state_q == TB_TRACE);
  assign out_bit   = out_valid & cur_q[M-1];
  assign out_last  = out_valid & (rcol_q == '0);
  assign rd_fire   = out_valid & out_ready;
  assign rd_done   = rd_fire & out_last;

  // Write pointer: advance per accepted step, flip banks on frame close.
  always_comb begin
    wbank_d = wbank_q;
    wcol_d  = wcol_q;
    if (wr_close) begin
      wbank_d = ~wbank_q;
      wcol_d  = '0;
    end else if (wr_fire) begin
      wcol_d = wcol_q + COL_W'(1);
    end
  end

  // Bank occupancy: close and release hit different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (wr_close) begin
      full_d[wbank_q] = 1'b1;
    end
    if (rd_done) begin
      full_d[rbank_q] = 1'b0;
    end
  end

  // Traceback FSM: load end state in IDLE, walk survivors back in TRACE.
  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    rcol_d  = rcol_q;
    cur_d   = cur_q;
    unique case (state_q)
      TB_IDLE: begin
        if (full_q[rbank_q]) begin
          cur_d   = sst_q[rbank_q];
          rcol_d  = COL_W'(len_q[rbank_q] - LEN_W'(1));
          state_d = TB_TRACE;
        end
      end
      TB_TRACE: begin
        if (rd_fire) begin
          // Predecessor state: shift the survivor decision in at the LSB.
          cur_d = {cur_q[M-2:0], rbit};
          if (rcol_q == '0) begin
            rbank_d = ~rbank_q;
            state_d = TB_IDLE;
          end else begin
            rcol_d = rcol_q - COL_W'(1);
          end
        end
      end
      default: state_d = TB_IDLE;
    endcase
  end

  // Control registers: pointers, occupancy and FSM state cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q <= 1'b0;
      wcol_q  <= '0;
      full_q  <= '0;
      state_q <= TB_IDLE;
      rbank_q <= 1'b0;
      rcol_q  <= '0;
    end else begin
      wbank_q <= wbank_d;
      wcol_q  <= wcol_d;
      full_q  <= full_d;
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcol_q  <= rcol_d;
    end
  end

  // Per-bank frame metadata and the trace state register; only read when flagged valid.
  always_ff @(posedge clk) begin
    if (wr_close) begin
      len_q[wbank_q] <= LEN_W'(wcol_q) + LEN_W'(1);
      sst_q[wbank_q] <= start_state;
    end
    cur_q <= cur_d;
  end

endmodule

// File: doc/viterbi_tbu.md
# viterbi_tbu

Parametrised survivor-memory and traceback unit for the Viterbi decoder. It sits between the add-compare-select stage, which supplies one decision bit per trellis state per step, and the decoded-bit sink. It replaces the fixed 4-state, 8-deep survivor store with a configurable constraint length and frame depth. Ping-pong banks let one frame be written while the previous frame is traced back, and the unit emits decoded bits under a valid/ready handshake.

## Interface
- `K`, default 3: constraint length. `M = K-1` is the state width; `NUM_ST = 2**M` (legal `K` range is 3..7).
- `FRAME_LEN`, default 8: maximum trellis steps per frame, i.e. columns per bank (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dec_valid`  in  1  decision vector present.
- `dec_ready`  out  1  unit can accept a decision vector.
- `dec_vec`  in  NUM_ST  bit s is the survivor decision for state s at this step.
- `dec_last`  in  1  this beat closes the frame.
- `start_state`  in  M  best-metric end state; sampled on the frame-closing beat.
- `out_valid`  out  1  decoded bit present.
- `out_ready`  in  1  sink accepts the bit.
- `out_bit`  out  1  decoded bit.
- `out_last`  out  1  marks the earliest bit (column 0) of the frame.

## Operation
- Two banks, each `FRAME_LEN × NUM_ST` bits. Per-bank state: `full` flag, stored length `len` (1..FRAME_LEN), stored `start_state`.
- **Write side**
  - A write happens when `dec_valid && dec_ready`. It stores `dec_vec` into column `wcol` of bank `wbank`, then `wcol++`.
  - The frame closes on `dec_last`, or on the write to column `FRAME_LEN-1` (forced close).
  - On close: `len = wcol+1`, `start_state` is latched, `full[wbank]` is set, `wbank` toggles, `wcol` returns to 0.
  - `dec_ready = !full[wbank]`. It is registered-state driven, with no combinational path from `out_ready`.
- **Traceback FSM** (`IDLE`, `TRACE`)
  - `IDLE`: if `full[rbank]`, load `cur = start_state[rbank]` and `rcol = len-1`, then go to `TRACE`.
  - `TRACE`: `out_valid=1`, `out_bit = cur[M-1]`, `out_last = (rcol==0)`.
  - On each `out_valid && out_ready`: `cur <= {cur[M-2:0], bank[rbank][rcol][cur]}` and `rcol--`.
  - On the `out_last` handshake: clear `full[rbank]`, toggle `rbank`, return to `IDLE`.
  - Without `out_ready`, all outputs are held stable.
- **Bit order:** bits leave in reverse time order (last step first).
- **Boundaries**
  - Both banks full: `dec_ready=0` until the traceback releases a bank.
  - Close and release on the same cycle: both take effect; `dec_ready` rises the next cycle.
  - A 1-step frame (`dec_last` on the first beat) gives exactly one bit, with `out_last=1`.
  - `dec_last` is ignored when there is no handshake.
- **Reset mid-operation:** all banks are flagged empty, pointers go to 0, the FSM goes to `IDLE`, and any partial frame or output is discarded. Array contents need not be cleared.

## Timing
- Reset values: `dec_ready=1`, `out_valid=0`, `out_bit=0`, `out_last=0`. Also `wbank=rbank=0` and `wcol=0`.
- Latency, closing handshake at cycle t with the traceback idle:
  - `IDLE` load occurs at t+1.
  - The first `out_valid` appears at t+2.
  - With `out_ready` held high, one bit per cycle follows, so `len` bits occupy t+2 … t+1+len.
- A back-to-back full-rate frame sustains throughput with 1 idle output cycle between frames (the `IDLE` load).
- The survivor read is a combinational read of the register array within the cycle.

## Structure
- Shared package `viterbi_pkg` holds:
  - `function num_states(k)`;
  - the state-width localparams;
  - the FSM enum `tb_state_t {TB_IDLE, TB_TRACE}`, which is shared with future sliding-window variants.
- One natural sub-module, `sv_bank`:
  - a single survivor bank, instantiated twice;
  - write port: column and vector;
  - read port: column and state index, returning one decision bit.

## Test plan
Parameters: K=3, FRAME_LEN=8, `out_ready=1` unless stated.
- All-zero decisions, 8 beats, `start_state=2'b00` → 8 bits `0`; `out_last` on the 8th bit; first `out_valid` 2 cycles after the closing beat.
- All-zero decisions, `start_state=2'b10` → bits `1,0,0,0,0,0,0,0`, `out_last` on the 8th.
- `dec_vec=4'b1111` every beat, `start_state=2'b11` → 8 bits `1`.
- Short frame: `dec_last` on beat 3, `start_state=2'b01`, all-zero decisions → bits `0,1,0`, `out_last` on the 3rd.
- Back-pressure and ping-pong:
  - Stimulus: `out_ready=0` while 3 frames are offered back to back.
  - Required response: `dec_ready` falls after frame 2 closes.
  - Releasing `out_ready` drains frame 1 with outputs stable while stalled; `dec_ready` reasserts one cycle after frame 1's `out_last` handshake; frame 3 is accepted.
- Assert `rst` midway through a traceback → the next cycle shows the reset values. A new frame afterwards decodes correctly with no stale bits.
